snoop_bus_arbiter: RTL and testbench

- N-CPU snooping bus controller that sits between the per-CPU caches and single-ported data memory.
- Performs round-robin arbitration of coherence transactions and broadcasts snoops to the non-requesting caches.
- Services each miss from memory, or cache-to-cache when a snooper holds the line dirty; in that case it writes the dirty data back to memory at the same time.
- Supersedes the fixed two-CPU bus controller. Adds CPU-count and word-width parameters, a bounded snoop-acknowledge window, and multi-word bus locking.

---
 rtl/snoop_bus_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Snooping bus controller for CPUS private caches sharing one single-ported
// data memory. It arbitrates coherence transactions round-robin, broadcasts
// snoops to the non-requesting caches, and services each miss either from
// memory or cache-to-cache. A cache-to-cache transfer writes the dirty line
// back to memory in the same cycle. A requester keeps the bus locked by
// holding cctrans.
module snoop_bus_arbiter #(
    parameter int unsigned CPUS          = 2,
    parameter int unsigned WORD_W        = 32,
    parameter int unsigned SNOOP_TIMEOUT = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     dwait,
    input  logic [WORD_W-1:0]        dload,
    output logic                     dREN,
    output logic                     dWEN,
    output logic [WORD_W-1:0]        dstore,
    output logic [WORD_W-1:0]        daddr,
    input  logic [CPUS-1:0]          ccif_dREN,
    input  logic [CPUS-1:0]          ccif_dWEN,
    input  logic [CPUS*WORD_W-1:0]   ccif_dstore,
    input  logic [CPUS*WORD_W-1:0]   ccif_daddr,
    input  logic [CPUS-1:0]          ccif_cctrans,
    input  logic [CPUS-1:0]          ccif_ccwrite,
    input  logic [CPUS-1:0]          ccif_halt,
    input  logic [CPUS-1:0]          ccif_flushed,
    output logic [CPUS-1:0]          ccif_dwait,
    output logic [CPUS*WORD_W-1:0]   ccif_dload,
    output logic [CPUS-1:0]          ccif_ccwait,
    output logic [CPUS-1:0]          ccif_ccinv,
    output logic [CPUS*WORD_W-1:0]   ccif_ccsnoopaddr,
    output logic [CPUS-1:0]          grant,
    output logic                     sys_halt
);

    localparam int unsigned IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int unsigned CNT_W = (SNOOP_TIMEOUT > 1) ? $clog2(SNOOP_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_SNOOP,
        S_C2C,
        S_MEMRD,
        S_HOLD
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  req_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [CPUS-1:0]   ack_set_q;
    logic              dirty_vld_q;
    logic [IDX_W-1:0]  dirty_idx_q;
    logic [CNT_W-1:0]  tcnt_q;
    logic              sys_halt_q;

    logic [WORD_W-1:0] c_addr  [CPUS];
    logic [WORD_W-1:0] c_store [CPUS];

    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic [CPUS-1:0]   req_oh;
    logic [CPUS-1:0]   ack_now;
    logic [CPUS-1:0]   dirty_now;
    logic [IDX_W-1:0]  dirty_first;
    logic              snoop_exit;
    logic              snoop_dirty;

    for (genvar g = 0; g < CPUS; g++) begin : g_unpack
        assign c_addr[g]  = ccif_daddr[g*WORD_W +: WORD_W];
        assign c_store[g] = ccif_dstore[g*WORD_W +: WORD_W];
    end

    assign req_oh      = CPUS'(1) << req_q;
    assign ack_now     = ccif_cctrans & ~req_oh;
    assign dirty_now   = ccif_cctrans & ccif_dWEN & ~req_oh;
    assign snoop_exit  = (&(ack_set_q | ack_now | req_oh)) ||
                         (tcnt_q == CNT_W'(SNOOP_TIMEOUT - 1));
    assign snoop_dirty = dirty_vld_q | (|dirty_now);
    assign sys_halt    = sys_halt_q;

    // Round-robin pick: first requester at or after rr_ptr, wrapping around.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < CPUS; k++) begin
            cand     = (32'(rr_ptr_q) + k) % CPUS;
            cand_idx = IDX_W'(cand);
            if (!pick_vld && ccif_cctrans[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    // Lowest-index dirty snooper among this cycle's dirty acks.
    always_comb begin
        dirty_first = '0;
        for (int unsigned k = CPUS; k > 0; k--) begin
            if (dirty_now[IDX_W'(k - 1)]) begin
                dirty_first = IDX_W'(k - 1);
            end
        end
    end

    // Bus controller state machine and arbitration bookkeeping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            rr_ptr_q    <= '0;
            ack_set_q   <= '0;
            dirty_vld_q <= 1'b0;
            dirty_idx_q <= '0;
            tcnt_q      <= '0;
            sys_halt_q  <= 1'b0;
        end else begin
            sys_halt_q <= (state_q == S_IDLE) && (&ccif_halt) && (&ccif_flushed);
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        req_q <= pick_idx;
                        if (ccif_dWEN[pick_idx]) begin
                            state_q <= S_WB;
                        end else if (ccif_dREN[pick_idx]) begin
                            state_q <= S_SNOOP;
                        end
                    end
                end
                S_WB: begin
                    if (!dwait) state_q <= S_HOLD;
                end
                S_SNOOP: begin
                    ack_set_q <= ack_set_q | ack_now;
                    tcnt_q    <= tcnt_q + CNT_W'(1);
                    if (!dirty_vld_q && (|dirty_now)) begin
                        dirty_vld_q <= 1'b1;
                        dirty_idx_q <= dirty_first;
                    end
                    // dirty_idx_q survives the exit so C2C can use it.
                    if (snoop_exit) begin
                        ack_set_q   <= '0;
                        dirty_vld_q <= 1'b0;
                        tcnt_q      <= '0;
                        state_q     <= snoop_dirty ? S_C2C : S_MEMRD;
                    end
                end
                S_C2C: begin
                    if (!dwait) state_q <= S_HOLD;
                end
                S_MEMRD: begin
                    if (!dwait) state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (!ccif_cctrans[req_q]) begin
                        state_q  <= S_IDLE;
                        rr_ptr_q <= (req_q == IDX_W'(CPUS - 1)) ? '0 : req_q + IDX_W'(1);
                    end else if (ccif_dWEN[req_q]) begin
                        state_q <= S_WB;
                    end else if (ccif_dREN[req_q]) begin
                        state_q <= S_SNOOP;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Memory and per-cache outputs decoded from the registered state.
    always_comb begin
        dREN             = 1'b0;
        dWEN             = 1'b0;
        dstore           = '0;
        daddr            = '0;
        ccif_dwait       = '1;
        ccif_dload       = '0;
        ccif_ccwait      = '0;
        ccif_ccinv       = '0;
        ccif_ccsnoopaddr = '0;
        grant            = (state_q == S_IDLE) ? '0 : req_oh;
        case (state_q)
            S_WB: begin
                dWEN              = 1'b1;
                daddr             = c_addr[req_q];
                dstore            = c_store[req_q];
                ccif_dwait[req_q] = dwait;
            end
            S_SNOOP: begin
                for (int unsigned j = 0; j < CPUS; j++) begin
                    if (IDX_W'(j) != req_q) begin
                        ccif_ccwait[IDX_W'(j)]                 = 1'b1;
                        ccif_ccinv[IDX_W'(j)]                  = ccif_ccwrite[req_q];
                        ccif_ccsnoopaddr[j*WORD_W +: WORD_W]   = c_addr[req_q];
                    end
                end
            end
            S_C2C: begin
                dWEN                                     = 1'b1;
                daddr                                    = c_addr[dirty_idx_q];
                dstore                                   = c_store[dirty_idx_q];
                ccif_dload[32'(req_q)*WORD_W +: WORD_W]  = c_store[dirty_idx_q];
                ccif_dwait[req_q]                        = dwait;
                ccif_dwait[dirty_idx_q]                  = dwait;
                ccif_ccwait[dirty_idx_q]                 = 1'b1;
            end
            S_MEMRD: begin
                dREN                                     = 1'b1;
                daddr                                    = c_addr[req_q];
                ccif_dload[32'(req_q)*WORD_W +: WORD_W]  = dload;
                ccif_dwait[req_q]                        = dwait;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: a two-cache instance for the
// coherence paths, locking and reset, and a four-cache instance for
// round-robin ordering.
module tb_snoop_bus_arbiter;

    logic CLK = 1'b0;
    logic RST;

    // Two-cache instance
    logic        dwait2;
    logic [31:0] dload2;
    logic        dREN2, dWEN2;
    logic [31:0] dstore2, daddr2;
    logic [1:0]  cdREN2, cdWEN2, cctrans2, ccwrite2, halt2, flushed2;
    logic [63:0] cdstore2, cdaddr2;
    logic [1:0]  cdwait2, ccwait2, ccinv2, grant2;
    logic [63:0] cdload2, snoop2;
    logic        sys_halt2;

    // Four-cache instance
    logic         dwait4;
    logic [31:0]  dload4;
    logic         dREN4, dWEN4;
    logic [31:0]  dstore4, daddr4;
    logic [3:0]   cdREN4, cdWEN4, cctrans4, ccwrite4, halt4, flushed4;
    logic [127:0] cdstore4, cdaddr4;
    logic [3:0]   cdwait4, ccwait4, ccinv4, grant4;
    logic [127:0] cdload4, snoop4;
    logic         sys_halt4;

    int n_cmp = 0;
    int n_err = 0;

    snoop_bus_arbiter #(.CPUS(2), .WORD_W(32), .SNOOP_TIMEOUT(8)) u2 (
        .CLK(CLK), .RST(RST), .dwait(dwait2), .dload(dload2),
        .dREN(dREN2), .dWEN(dWEN2), .dstore(dstore2), .daddr(daddr2),
        .ccif_dREN(cdREN2), .ccif_dWEN(cdWEN2), .ccif_dstore(cdstore2),
        .ccif_daddr(cdaddr2), .ccif_cctrans(cctrans2), .ccif_ccwrite(ccwrite2),
        .ccif_halt(halt2), .ccif_flushed(flushed2), .ccif_dwait(cdwait2),
        .ccif_dload(cdload2), .ccif_ccwait(ccwait2), .ccif_ccinv(ccinv2),
        .ccif_ccsnoopaddr(snoop2), .grant(grant2), .sys_halt(sys_halt2)
    );

    snoop_bus_arbiter #(.CPUS(4), .WORD_W(32), .SNOOP_TIMEOUT(8)) u4 (
        .CLK(CLK), .RST(RST), .dwait(dwait4), .dload(dload4),
        .dREN(dREN4), .dWEN(dWEN4), .dstore(dstore4), .daddr(daddr4),
        .ccif_dREN(cdREN4), .ccif_dWEN(cdWEN4), .ccif_dstore(cdstore4),
        .ccif_daddr(cdaddr4), .ccif_cctrans(cctrans4), .ccif_ccwrite(ccwrite4),
        .ccif_halt(halt4), .ccif_flushed(flushed4), .ccif_dwait(cdwait4),
        .ccif_dload(cdload4), .ccif_ccwait(ccwait4), .ccif_ccinv(ccinv4),
        .ccif_ccsnoopaddr(snoop4), .grant(grant4), .sys_halt(sys_halt4)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1;
        dwait2 = 1'b1; dload2 = '0; cdREN2 = '0; cdWEN2 = '0; cctrans2 = '0;
        ccwrite2 = '0; halt2 = '0; flushed2 = '0; cdstore2 = '0; cdaddr2 = '0;
        dwait4 = 1'b1; dload4 = '0; cdREN4 = '0; cdWEN4 = '0; cctrans4 = '0;
        ccwrite4 = '0; halt4 = '0; flushed4 = '0; cdstore4 = '0; cdaddr4 = '0;

        // Reset values
        #3;
        chk("rst_dwait2", cdwait2, 2'b11);
        chk("rst_dREN2", dREN2, 1'b0);
        chk("rst_dWEN2", dWEN2, 1'b0);
        chk("rst_daddr2", daddr2, 32'h0);
        chk("rst_dstore2", dstore2, 32'h0);
        chk("rst_dload2", cdload2, 64'h0);
        chk("rst_ccwait2", ccwait2, 2'b00);
        chk("rst_ccinv2", ccinv2, 2'b00);
        chk("rst_snoop2", snoop2, 64'h0);
        chk("rst_grant2", grant2, 2'b00);
        chk("rst_halt2", sys_halt2, 1'b0);
        chk("rst_dwait4", cdwait4, 4'hf);
        chk("rst_grant4", grant4, 4'h0);
        tick(); tick();
        RST = 1'b0;

        // Read miss 0x100 from cache0, clean ack, memory after 3 wait cycles
        cctrans2 = 2'b01; cdREN2 = 2'b01; cdaddr2[31:0] = 32'h100;
        #1 chk("t1_idle_grant", grant2, 2'b00);
        tick();
        cctrans2 = 2'b11;
        #1;
        chk("t1_snp_grant", grant2, 2'b01);
        chk("t1_snp_ccwait", ccwait2, 2'b10);
        chk("t1_snp_addr", snoop2, {32'h100, 32'h0});
        chk("t1_snp_inv", ccinv2, 2'b00);
        chk("t1_snp_dren", dREN2, 1'b0);
        chk("t1_snp_dwait", cdwait2, 2'b11);
        tick();
        cctrans2 = 2'b01;
        #1;
        chk("t1_mrd_dren", dREN2, 1'b1);
        chk("t1_mrd_daddr", daddr2, 32'h100);
        chk("t1_mrd_w1", cdwait2, 2'b11);
        chk("t1_mrd_ccwait", ccwait2, 2'b00);
        tick();
        #1 chk("t1_mrd_w2", cdwait2, 2'b11);
        tick();
        #1 chk("t1_mrd_w3", cdwait2, 2'b11);
        tick();
        dwait2 = 1'b0; dload2 = 32'hDEADBEEF;
        #1;
        chk("t1_mrd_dload", cdload2, {32'h0, 32'hDEADBEEF});
        chk("t1_mrd_done", cdwait2, 2'b10);
        tick();
        dwait2 = 1'b1; dload2 = '0; cctrans2 = 2'b00; cdREN2 = 2'b00;
        #1;
        chk("t1_hold_dwait", cdwait2, 2'b11);
        chk("t1_hold_grant", grant2, 2'b01);
        chk("t1_hold_dren", dREN2, 1'b0);
        chk("t1_hold_dload", cdload2, 64'h0);
        tick();
        #1 chk("t1_idle2_grant", grant2, 2'b00);

        // rr_ptr now 1: simultaneous writebacks go to cache1 first
        cctrans2 = 2'b11; cdWEN2 = 2'b11; dwait2 = 1'b0;
        cdaddr2 = {32'h20, 32'h10}; cdstore2 = {32'h222, 32'h111};
        tick();
        #1;
        chk("rr_wb1_grant", grant2, 2'b10);
        chk("rr_wb1_dwen", dWEN2, 1'b1);
        chk("rr_wb1_daddr", daddr2, 32'h20);
        chk("rr_wb1_dstore", dstore2, 32'h222);
        chk("rr_wb1_dwait", cdwait2, 2'b01);
        cctrans2 = 2'b01; cdWEN2 = 2'b01;
        tick();
        #1 chk("rr_hold1_grant", grant2, 2'b10);
        tick();
        #1 chk("rr_idle_grant", grant2, 2'b00);
        tick();
        #1;
        chk("rr_wb0_grant", grant2, 2'b01);
        chk("rr_wb0_daddr", daddr2, 32'h10);
        chk("rr_wb0_dstore", dstore2, 32'h111);
        cctrans2 = 2'b00; cdWEN2 = 2'b00;
        tick(); tick();
        dwait2 = 1'b1;

        // BusRdX 0x200 from cache0, cache1 supplies dirty data
        cctrans2 = 2'b01; cdREN2 = 2'b01; ccwrite2 = 2'b01; cdaddr2[31:0] = 32'h200;
        tick();
        cctrans2 = 2'b11; cdWEN2 = 2'b10;
        cdaddr2[63:32] = 32'h200; cdstore2[63:32] = 32'h12345678;
        #1;
        chk("t2_snp_inv", ccinv2, 2'b10);
        chk("t2_snp_addr", snoop2[63:32], 32'h200);
        tick();
        cctrans2 = 2'b01;
        #1;
        chk("t2_c2c_dwen", dWEN2, 1'b1);
        chk("t2_c2c_daddr", daddr2, 32'h200);
        chk("t2_c2c_dstore", dstore2, 32'h12345678);
        chk("t2_c2c_dload", cdload2[31:0], 32'h12345678);
        chk("t2_c2c_wait", cdwait2, 2'b11);
        chk("t2_c2c_ccwait", ccwait2, 2'b10);
        chk("t2_c2c_dren", dREN2, 1'b0);
        dwait2 = 1'b0;
        #1 chk("t2_c2c_done", cdwait2, 2'b00);
        tick();
        dwait2 = 1'b1; cctrans2 = 2'b00; cdREN2 = 2'b00; ccwrite2 = 2'b00; cdWEN2 = 2'b00;
        #1;
        chk("t2_hold_dwen", dWEN2, 1'b0);
        chk("t2_hold_dwait", cdwait2, 2'b11);
        chk("t2_hold_ccwait", ccwait2, 2'b00);
        tick();

        // Silent snooper: SNOOP lasts exactly 8 cycles, stale acks not reused
        cctrans2 = 2'b01; cdREN2 = 2'b01; cdaddr2[31:0] = 32'h400;
        tick();
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t3_snp_dren", dREN2, 1'b0);
            chk("t3_snp_ccwait", ccwait2, 2'b10);
            tick();
        end
        dwait2 = 1'b0; dload2 = 32'hCAFEF00D;
        #1;
        chk("t3_mrd_dren", dREN2, 1'b1);
        chk("t3_mrd_daddr", daddr2, 32'h400);
        chk("t3_mrd_dload", cdload2, {32'h0, 32'hCAFEF00D});
        chk("t3_mrd_dwait", cdwait2, 2'b10);
        tick();
        dwait2 = 1'b1; dload2 = '0; cctrans2 = 2'b00; cdREN2 = 2'b00;
        tick();

        // Two-word locked writeback from cache1 with cache0 competing
        dwait2 = 1'b0; cctrans2 = 2'b11; cdWEN2 = 2'b11;
        cdaddr2 = {32'h300, 32'h700}; cdstore2 = {32'hA1, 32'hB0};
        tick();
        #1;
        chk("t5_wb1_grant", grant2, 2'b10);
        chk("t5_wb1_daddr", daddr2, 32'h300);
        chk("t5_wb1_dstore", dstore2, 32'hA1);
        tick();
        #1;
        chk("t5_hold1_grant", grant2, 2'b10);
        chk("t5_hold1_dwait", cdwait2, 2'b11);
        chk("t5_hold1_dwen", dWEN2, 1'b0);
        cdaddr2[63:32] = 32'h304; cdstore2[63:32] = 32'hA2;
        tick();
        #1;
        chk("t5_wb2_grant", grant2, 2'b10);
        chk("t5_wb2_daddr", daddr2, 32'h304);
        chk("t5_wb2_dstore", dstore2, 32'hA2);
        cdWEN2 = 2'b01;
        tick();
        #1 chk("t5_hold2_grant", grant2, 2'b10);
        cctrans2 = 2'b01;
        tick();
        #1 chk("t5_idle_grant", grant2, 2'b00);
        tick();
        #1;
        chk("t5_wb0_grant", grant2, 2'b01);
        chk("t5_wb0_daddr", daddr2, 32'h700);
        chk("t5_wb0_dstore", dstore2, 32'hB0);
        cctrans2 = 2'b00; cdWEN2 = 2'b00;
        tick(); tick();

        // Four caches: move rr_ptr to 1, then 0,2,3 contend -> 2,3,0
        dwait4 = 1'b0; cctrans4 = 4'b0001; cdWEN4 = 4'b0001; cdaddr4[31:0] = 32'h40;
        tick();
        cctrans4 = 4'b0000; cdWEN4 = 4'b0000;
        tick(); tick();
        #1 chk("t4_idle0_grant", grant4, 4'b0000);
        cctrans4 = 4'b1101; cdWEN4 = 4'b1101;
        cdaddr4 = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
        tick();
        #1;
        chk("t4_wb2_grant", grant4, 4'b0100);
        chk("t4_wb2_daddr", daddr4, 32'h1002);
        cdWEN4 = 4'b1001;
        tick();
        #1 chk("t4_hold2a_grant", grant4, 4'b0100);
        tick();
        #1 chk("t4_hold2b_grant", grant4, 4'b0100);
        cctrans4 = 4'b1001;
        tick();
        #1 chk("t4_idle1_grant", grant4, 4'b0000);
        tick();
        #1;
        chk("t4_wb3_grant", grant4, 4'b1000);
        chk("t4_wb3_daddr", daddr4, 32'h1003);
        cdWEN4 = 4'b0001;
        tick();
        #1 chk("t4_hold3_grant", grant4, 4'b1000);
        cctrans4 = 4'b0001;
        tick();
        #1 chk("t4_idle2_grant", grant4, 4'b0000);
        tick();
        #1;
        chk("t4_wb0_grant", grant4, 4'b0001);
        chk("t4_wb0_daddr", daddr4, 32'h1000);
        cctrans4 = 4'b0000; cdWEN4 = 4'b0000;
        tick(); tick();

        // Reset pulse during a stalled memory read, then system halt
        dwait2 = 1'b1; cctrans2 = 2'b10; cdREN2 = 2'b10; cdaddr2[63:32] = 32'h500;
        tick();
        cctrans2 = 2'b11;
        tick();
        cctrans2 = 2'b10;
        #1;
        chk("t6_mrd_dren", dREN2, 1'b1);
        chk("t6_mrd_daddr", daddr2, 32'h500);
        #1 RST = 1'b1;
        #1;
        chk("t6_rst_dren", dREN2, 1'b0);
        chk("t6_rst_dwait", cdwait2, 2'b11);
        chk("t6_rst_grant", grant2, 2'b00);
        chk("t6_rst_daddr", daddr2, 32'h0);
        tick();
        cctrans2 = 2'b00; cdREN2 = 2'b00; RST = 1'b0;
        halt2 = 2'b11; flushed2 = 2'b11;
        #1;
        chk("t6_halt_pre", sys_halt2, 1'b0);
        chk("t6_post_dren", dREN2, 1'b0);
        tick();
        #1;
        chk("t6_halt_set", sys_halt2, 1'b1);
        chk("t6_halt_grant", grant2, 2'b00);
        chk("t6_halt_dren", dREN2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
